// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle.
// Board logic drives en/mode/speed; the generator returns the LED drive and a tick strobe.
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 8
);
    logic                en;
    logic [1:0]          mode;
    logic [1:0]          speed;
    logic [NUM_LEDS-1:0] led;
    logic                tick;

    modport master (output en, mode, speed, input led, tick);
    modport slave  (input en, mode, speed, output led, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern generator: binary count, bouncing scan,
// all-blink and PWM breathe, paced by a programmable tick prescaler.
module led_pattern_gen #(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 6250000,
    parameter int PWM_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    led_pattern_gen_if.slave bus
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0]       POS_MAX  = PW'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        M_BINARY  = 2'd0,
        M_SCAN    = 2'd1,
        M_BLINK   = 2'd2,
        M_BREATHE = 2'd3
    } mode_e;

    // Mode tracking
    mode_e active_mode;
    mode_e mode_nx;
    logic  mode_chg;

    // Prescaler
    logic [CW-1:0] cnt;
    logic [31:0]   period_m1;
    logic          wrap;
    logic          hit;

    // Pattern state
    logic [NUM_LEDS-1:0] step;
    logic [PW-1:0]       pos;
    logic                pos_dn;
    logic                phase;
    logic [PWM_BITS-1:0] duty;
    logic                duty_dn;
    logic [PWM_BITS-1:0] pwm_cnt;

    // Next-step values for the two bouncing counters
    logic [PW-1:0]       pos_nx;
    logic                pos_dn_nx;
    logic [PWM_BITS-1:0] duty_nx;
    logic                duty_dn_nx;

    // Outputs
    logic [NUM_LEDS-1:0] led_nx;
    logic [NUM_LEDS-1:0] led_scan;
    logic [NUM_LEDS-1:0] led_q;
    logic                tick_q;

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

    // Tick period shrinks by powers of two with speed; compared with >= so a
    // speed-up that lands below the current count wraps on the very next cycle.
    assign period_m1 = (32'(TICK_DIV) >> bus.speed) - 32'd1;
    assign wrap      = (32'(cnt) >= period_m1);
    assign mode_chg  = (bus.mode != active_mode);
    // A mode change outranks a coincident tick.
    assign hit       = bus.en && !mode_chg && wrap;

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active_mode <= M_BINARY;
        else        active_mode <= mode_nx;
    end

    // Next mode: follow the requested mode whenever it differs
    always_comb begin
        mode_nx = active_mode;
        if (mode_chg) mode_nx = mode_e'(bus.mode);
    end

    // Prescaler count; restarts on a mode change, holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (mode_chg) cnt <= '0;
        else if (bus.en)   cnt <= wrap ? '0 : cnt + CW'(1);
    end

    // Registered tick strobe, one cycle per pattern step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= hit;
    end

    // Free-running PWM counter for breathe mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pwm_cnt <= '0;
        else if (mode_chg) pwm_cnt <= '0;
        else if (bus.en)   pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Scan position bounce: the end LED flips direction on the same tick so
    // it is never shown twice in a row
    always_comb begin
        pos_nx    = pos;
        pos_dn_nx = pos_dn;
        if (!pos_dn) begin
            if (pos == POS_MAX) begin
                pos_dn_nx = 1'b1;
                pos_nx    = pos - PW'(1);
            end else begin
                pos_nx    = pos + PW'(1);
            end
        end else begin
            if (pos == '0) begin
                pos_dn_nx = 1'b0;
                pos_nx    = pos + PW'(1);
            end else begin
                pos_nx    = pos - PW'(1);
            end
        end
    end

    // Breathe duty bounce, same no-repeat rule as the scan
    always_comb begin
        duty_nx    = duty;
        duty_dn_nx = duty_dn;
        if (!duty_dn) begin
            if (duty == DUTY_MAX) begin
                duty_dn_nx = 1'b1;
                duty_nx    = duty - PWM_BITS'(1);
            end else begin
                duty_nx    = duty + PWM_BITS'(1);
            end
        end else begin
            if (duty == '0) begin
                duty_dn_nx = 1'b0;
                duty_nx    = duty + PWM_BITS'(1);
            end else begin
                duty_nx    = duty - PWM_BITS'(1);
            end
        end
    end

    // Pattern state: cleared on mode change, advanced only on tick for the active mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            pos     <= '0;
            pos_dn  <= 1'b0;
            phase   <= 1'b0;
            duty    <= '0;
            duty_dn <= 1'b0;
        end else if (mode_chg) begin
            step    <= '0;
            pos     <= '0;
            pos_dn  <= 1'b0;
            phase   <= 1'b0;
            duty    <= '0;
            duty_dn <= 1'b0;
        end else if (hit) begin
            case (active_mode)
                M_BINARY: step <= step + NUM_LEDS'(1);
                M_SCAN: begin
                    pos    <= pos_nx;
                    pos_dn <= pos_dn_nx;
                end
                M_BLINK: phase <= ~phase;
                M_BREATHE: begin
                    duty    <= duty_nx;
                    duty_dn <= duty_dn_nx;
                end
                default: ;
            endcase
        end
    end

    // One-hot decode of the scan position
    always_comb begin
        led_scan      = '0;
        led_scan[pos] = 1'b1;
    end

    // Output decode: LED image for the active pattern
    always_comb begin
        led_nx = '0;
        case (active_mode)
            M_BINARY:  led_nx = step;
            M_SCAN:    led_nx = led_scan;
            M_BLINK:   led_nx = {NUM_LEDS{phase}};
            M_BREATHE: led_nx = {NUM_LEDS{pwm_cnt < duty}};
            default:   led_nx = '0;
        endcase
    end

    // Registered LED drive, forced dark while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= bus.en ? led_nx : '0;
    end

endmodule
